// File: rtl/square_iter.sv
// Iterative unsigned squarer: WIDTH-bit operand -> 2*WIDTH-bit square, one shift-add per clock.
// Latency: WIDTH cycles from accepted start to dataready_out; WIDTH+1 cycles per result back-to-back.
// Backpressure: one-entry pending buffer absorbs a start while busy; a further start is dropped and flagged.
module square_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     num_in,
    input  logic                 start,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   num_out,
    output logic                 dataready_out,
    output logic                 drop_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_p;
    logic                 r_pv;

    logic                 w_load_num;
    logic                 w_load_pend;
    logic                 w_step;
    logic                 w_last;
    logic                 w_pend_wr;
    logic                 w_drop;

    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;

    // Partial product for the current bit: A shifted by CNT when A[CNT] is set.
    always_comb begin
        w_a_ext   = {{WIDTH{1'b0}}, r_a};
        w_addend  = r_a[r_cnt] ? (w_a_ext << r_cnt) : '0;
        w_acc_sum = r_acc + w_addend;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; the pending entry always wins over a fresh start in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load_num  = 1'b0;
        w_load_pend = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_pend_wr   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load_num  = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
                if (start) begin
                    if (r_pv) begin
                        w_drop = 1'b1;
                    end else begin
                        w_pend_wr = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (r_pv) begin
                    w_load_pend = 1'b1;
                    w_pend_wr   = start;
                    w_state_nxt = S_CALC;
                end else if (start) begin
                    w_load_num  = 1'b1;
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand, accumulator and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load_num) begin
            r_a   <= num_in;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_load_pend) begin
            r_a   <= r_p;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_sum;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Pending buffer: a write in the same cycle as the drain keeps PV set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p  <= '0;
            r_pv <= 1'b0;
        end else if (w_pend_wr) begin
            r_p  <= num_in;
            r_pv <= 1'b1;
        end else if (w_load_pend) begin
            r_pv <= 1'b0;
        end
    end

    // Registered result and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_out       <= '0;
            dataready_out <= 1'b0;
            drop_out      <= 1'b0;
        end else begin
            dataready_out <= w_last;
            drop_out      <= w_drop;
            if (w_last) begin
                num_out <= w_acc_sum;
            end
        end
    end

    assign busy = (r_state != S_IDLE) || r_pv;

endmodule

// File: tb/tb_square_iter.sv
// Directed bench for square_iter: table of single requests plus queued, drop, DONE-start and reset sequences.
// Latency: checks the exact cycle of each dataready_out / drop_out pulse relative to the accepting edge.
// Backpressure: exercises pending-buffer fill, overflow drop and restart in the DONE cycle.
module tb_square_iter;

    logic        clk;
    logic        rst;
    logic [15:0] num_in;
    logic        start;
    logic        busy;
    logic [31:0] num_out;
    logic        dataready_out;
    logic        drop_out;

    int checks;
    int errors;
    int cyc;
    int busy_cnt;
    int dr_cyc[$];
    logic [31:0] dr_val[$];
    int drop_cyc[$];

    square_iter #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .num_in       (num_in),
        .start        (start),
        .busy         (busy),
        .num_out      (num_out),
        .dataready_out(dataready_out),
        .drop_out     (drop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic [31:0] sq;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock edge, then sample outputs 1 time unit later and log events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (dataready_out) begin
            dr_cyc.push_back(cyc);
            dr_val.push_back(num_out);
        end
        if (drop_out) drop_cyc.push_back(cyc);
    endtask

    task automatic clear_log();
        busy_cnt = 0;
        dr_cyc.delete();
        dr_val.delete();
        drop_cyc.delete();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] val_at(input int idx);
        return (idx < dr_val.size()) ? dr_val[idx] : 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_at(input int idx);
        return (idx < dr_cyc.size()) ? dr_cyc[idx] : -1000;
    endfunction

    // Issue one start from idle and check result, latency, busy length and no drop.
    task automatic run_single(input logic [15:0] op, input logic [31:0] sq);
        int c0;
        clear_log();
        start  = 1'b1;
        num_in = op;
        tick();
        c0     = cyc;
        start  = 1'b0;
        num_in = '0;
        ticks(30);
        check($sformatf("single_%0d_count", op), dr_val.size(), 1);
        check($sformatf("single_%0d_value", op), val_at(0), sq);
        check($sformatf("single_%0d_latency", op), cyc_at(0) - c0, 16);
        check($sformatf("single_%0d_busy_cycles", op), busy_cnt, 17);
        check($sformatf("single_%0d_drops", op), drop_cyc.size(), 0);
        check($sformatf("single_%0d_hold", op), num_out, sq);
    endtask

    initial begin
        vec_t vecs[5];
        int   c0;

        vecs[0] = '{op: 16'd9,     sq: 32'd81};
        vecs[1] = '{op: 16'd0,     sq: 32'd0};
        vecs[2] = '{op: 16'd1,     sq: 32'd1};
        vecs[3] = '{op: 16'd1000,  sq: 32'd1000000};
        vecs[4] = '{op: 16'd65535, sq: 32'hFFFE0001};

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        num_in = '0;
        clear_log();
        ticks(3);
        check("reset_num_out", num_out, 0);
        check("reset_dataready", dataready_out, 0);
        check("reset_drop", drop_out, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        ticks(2);

        for (int i = 0; i < 5; i++) begin
            run_single(vecs[i].op, vecs[i].sq);
        end

        // Queued request: 3 at E0, 1000 at E4.
        clear_log();
        start = 1'b1; num_in = 16'd3;
        tick(); c0 = cyc;
        start = 1'b0;
        ticks(3);
        start = 1'b1; num_in = 16'd1000;
        tick();
        start = 1'b0;
        ticks(45);
        check("queued_count", dr_val.size(), 2);
        check("queued_first", val_at(0), 9);
        check("queued_second", val_at(1), 1000000);
        check("queued_first_latency", cyc_at(0) - c0, 16);
        check("queued_spacing", cyc_at(1) - cyc_at(0), 17);
        check("queued_drops", drop_cyc.size(), 0);

        // Pending overflow: 4 at E0, 5 at E3, 6 at E6.
        clear_log();
        start = 1'b1; num_in = 16'd4;
        tick(); c0 = cyc;
        start = 1'b0;
        ticks(2);
        start = 1'b1; num_in = 16'd5;
        tick();
        start = 1'b0;
        ticks(2);
        start = 1'b1; num_in = 16'd6;
        tick();
        start = 1'b0;
        ticks(45);
        check("ovf_drop_count", drop_cyc.size(), 1);
        check("ovf_drop_cycle", (drop_cyc.size() > 0) ? drop_cyc[0] - c0 : -1, 6);
        check("ovf_result_count", dr_val.size(), 2);
        check("ovf_first", val_at(0), 16);
        check("ovf_second", val_at(1), 25);

        // Start during DONE with nothing pending.
        clear_log();
        start = 1'b1; num_in = 16'd81;
        tick(); c0 = cyc;
        start = 1'b0;
        ticks(16);
        check("done_in_done_cycle", dataready_out, 1);
        start = 1'b1; num_in = 16'd7;
        tick();
        start = 1'b0;
        ticks(40);
        check("done_count", dr_val.size(), 2);
        check("done_first", val_at(0), 6561);
        check("done_second", val_at(1), 49);
        check("done_spacing", cyc_at(1) - cyc_at(0), 17);
        check("done_busy_continuous", busy_cnt, 34);
        check("done_drops", drop_cyc.size(), 0);

        // Reset eight cycles into a computation of 200.
        clear_log();
        start = 1'b1; num_in = 16'd200;
        tick();
        start = 1'b0;
        ticks(8);
        rst = 1'b1;
        #1;
        check("midrst_num_out", num_out, 0);
        check("midrst_dataready", dataready_out, 0);
        check("midrst_drop", drop_out, 0);
        check("midrst_busy", busy, 0);
        ticks(2);
        rst = 1'b0;
        ticks(30);
        check("midrst_no_result", dr_val.size(), 0);
        run_single(16'd12, 32'd144);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
